id_regfile_dump_ctrl: RTL and testbench
=======================================

Name: id_regfile_dump_ctrl

Overview:
Sequencer that shares read port 1 of the ID-stage register file between the pipeline and a debug dump engine. On a start request while the processor is halted, it takes the port and reads registers 0..SIZE_REG-1 in order. Each word is streamed out over a valid/ready handshake toward the debug UART transmitter. It sits between the ID decoder's rs/rt outputs and the register file address inputs.

Parameters:
NB_DATA, 32, register data width
NB_REG, 5, register address width
SIZE_REG, 32, number of registers dumped (must be <= 2**NB_REG)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
i_dump_start  input  1  dump request, sampled only in IDLE
i_halted  input  1  pipeline halted/drained; start accepted only when high
i_pipe_rs  input  NB_REG  pipeline read address for port 1
i_pipe_rt  input  NB_REG  pipeline read address for port 2
o_rf_addr_1  output  NB_REG  register file read address 1
o_rf_addr_2  output  NB_REG  register file read address 2, always i_pipe_rt
i_rf_data_1  input  NB_DATA  register file read data 1, combinational from o_rf_addr_1
o_tx_data  output  NB_DATA  dumped word
o_tx_valid  output  1  o_tx_data valid
i_tx_ready  input  1  consumer accepts word
o_index  output  NB_REG  register currently being dumped
o_pipe_stall  output  1  dump owns read port 1; pipeline must hold IF/ID
o_busy  output  1  state != IDLE
o_done  output  1  one-cycle pulse at end of dump

Behaviour:
- Reset (synchronous, i_reset=1 at an edge): state=IDLE, index=0, o_tx_data=0, o_tx_valid=0, o_done=0, o_busy=0, o_pipe_stall=0.
- Reset has priority over every event and aborts a dump mid-operation. No o_done pulse is produced.
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - o_rf_addr_1 = i_pipe_rs (combinational pass-through).
  - If i_dump_start & i_halted, go to READ and set index=0.
  - If i_halted=0, i_dump_start is ignored. It is not queued.
- READ:
  - o_rf_addr_1 = index.
  - At the edge, o_tx_data <= i_rf_data_1, o_tx_valid <= 1, go to SEND.
- SEND:
  - o_tx_data and o_tx_valid are held stable until a handshake (o_tx_valid & i_tx_ready at an edge).
  - o_rf_addr_1 = index.
  - On handshake:
    - o_tx_valid <= 0.
    - If index == SIZE_REG-1, go to DONE.
    - Otherwise, index <= index+1 and go to READ.
  - If i_tx_ready is high before valid, nothing happens. Only the AND of the two counts.
- DONE:
  - o_done=1 for exactly this cycle. o_pipe_stall=0.
  - o_rf_addr_1 = i_pipe_rs.
  - Go to IDLE next cycle with index <= 0.
- o_pipe_stall = 1 in READ and SEND only. o_busy = 1 in READ, SEND and DONE.
- i_dump_start while busy is ignored. No restart and no second dump is queued.
- Register 0 is dumped like any other register (value as read, normally 0).
- Timing with i_tx_ready held high:
  - start seen at edge 0 → READ in cycle 1 → first valid in cycle 2 → handshake at end of cycle 2 → READ again.
  - Each word takes 2 cycles. SIZE_REG=32 gives 64 cycles from the first READ to DONE.
- Back-pressure: each cycle of i_tx_ready=0 in SEND adds one cycle. There is no timeout.
- index never wraps. The last handshake exits to DONE, not to index 0.
- o_index = index register. It is 0 in IDLE.
- Register file writes (i_write) are not blocked by this block. Consistency relies on i_halted.

Test Plan:
- Reset then idle: i_pipe_rs=5, i_pipe_rt=9 → o_rf_addr_1=5, o_rf_addr_2=9, o_tx_valid=0, o_busy=0, o_pipe_stall=0.
- Full dump, ready always high: regfile preloaded with reg[n]=0x1000+n (n>0), reg0=0, start with i_halted=1 → 32 words in order 0x0, 0x1001 … 0x101F.
  - Valid every other cycle.
  - o_done pulses exactly once, 65 cycles after the start edge.
  - o_pipe_stall high for 64 cycles.
- Back-pressure: ready low for 3 cycles during word 7 → o_tx_data=0x1007 held with valid=1 for 4 cycles. The word is sent once and total dump time grows by 3.
- Start rejected: i_dump_start=1 with i_halted=0 → stays IDLE, no valid.
- Start during busy: a second i_dump_start mid-dump → ignored, exactly 32 words.
- Reset mid-operation: i_reset at word 12 in SEND → next cycle IDLE, valid=0, index=0, no o_done pulse. A new start then dumps from register 0.

Source files
------------

// File: rtl/id_regfile_dump_ctrl.sv
// Debug dump sequencer: borrows register file read port 1 while the core is halted
// and streams registers 0..SIZE_REG-1 out over a valid/ready handshake.
module id_regfile_dump_ctrl #(
    parameter int NB_DATA  = 32,
    parameter int NB_REG   = 5,
    parameter int SIZE_REG = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_dump_start,
    input  logic               i_halted,
    input  logic [NB_REG-1:0]  i_pipe_rs,
    input  logic [NB_REG-1:0]  i_pipe_rt,
    output logic [NB_REG-1:0]  o_rf_addr_1,
    output logic [NB_REG-1:0]  o_rf_addr_2,
    input  logic [NB_DATA-1:0] i_rf_data_1,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic [NB_REG-1:0]  o_index,
    output logic               o_pipe_stall,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [NB_REG-1:0] LAST_INDEX = NB_REG'(SIZE_REG - 1);

    state_t              state_q, state_d;
    logic [NB_REG-1:0]   index_q, index_d;
    logic [NB_DATA-1:0]  tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic [NB_REG-1:0]   rf_addr_1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            index_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        rf_addr_1  = i_pipe_rs;
        case (state_q)
            IDLE: begin
                // A start without a halted pipeline is dropped, not remembered.
                if (i_dump_start && i_halted) begin
                    state_d = READ;
                    index_d = '0;
                end
            end
            READ: begin
                rf_addr_1  = index_q;
                tx_data_d  = i_rf_data_1;
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                rf_addr_1 = index_q;
                if (tx_valid_q && i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (index_q == LAST_INDEX) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                index_d = '0;
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
            end
        endcase
    end

    assign o_rf_addr_1  = rf_addr_1;
    assign o_rf_addr_2  = i_pipe_rt;
    assign o_tx_data    = tx_data_q;
    assign o_tx_valid   = tx_valid_q;
    assign o_index      = index_q;
    assign o_pipe_stall = (state_q == READ) || (state_q == SEND);
    assign o_busy       = (state_q != IDLE);
    assign o_done       = (state_q == DONE);

endmodule

// File: tb/tb_id_regfile_dump_ctrl.sv
// Directed bench for id_regfile_dump_ctrl with a behavioural register file
// holding reg[n] = 0x1000+n (reg0 = 0).
module tb_id_regfile_dump_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_dump_start;
    logic        i_halted;
    logic [4:0]  i_pipe_rs;
    logic [4:0]  i_pipe_rt;
    logic [4:0]  o_rf_addr_1;
    logic [4:0]  o_rf_addr_2;
    logic [31:0] i_rf_data_1;
    logic [31:0] o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [4:0]  o_index;
    logic        o_pipe_stall;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    // Register file read is combinational from address 1
    assign i_rf_data_1 = (o_rf_addr_1 == 5'd0) ? 32'h0 : (32'h1000 + {27'd0, o_rf_addr_1});

    id_regfile_dump_ctrl #(.NB_DATA(32), .NB_REG(5), .SIZE_REG(32)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_dump_start (i_dump_start),
        .i_halted     (i_halted),
        .i_pipe_rs    (i_pipe_rs),
        .i_pipe_rt    (i_pipe_rt),
        .o_rf_addr_1  (o_rf_addr_1),
        .o_rf_addr_2  (o_rf_addr_2),
        .i_rf_data_1  (i_rf_data_1),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_index      (o_index),
        .o_pipe_stall (o_pipe_stall),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic applyStimulus();
        @(posedge i_clk);
        #1;
    endtask

    // Runs one dump from the start edge; mode 0 ready high, 1 back-pressure on
    // word 7, 2 extra start pulses mid-dump. Returns observed statistics.
    task automatic runDump(input int mode, output int words, output int validCycles,
                           output int stallCycles, output int doneCount,
                           output int doneCycle, output int held7);
        int cyc;
        int stallLeft;
        logic [31:0] expWord;
        words = 0; validCycles = 0; stallCycles = 0;
        doneCount = 0; doneCycle = 0; held7 = 0;
        stallLeft = 3;
        i_halted     = 1'b1;
        i_dump_start = 1'b1;
        i_tx_ready   = 1'b1;
        applyStimulus();
        i_dump_start = 1'b0;
        checkOutput("first_read_addr1", 32'(o_rf_addr_1), 32'd0);
        checkOutput("first_read_stall", 32'(o_pipe_stall), 32'd1);
        cyc = 1;
        while (cyc < 300) begin
            i_tx_ready   = 1'b1;
            i_dump_start = (mode == 2 && cyc >= 20 && cyc < 24) ? 1'b1 : 1'b0;
            if (mode == 1 && o_tx_valid && o_tx_data == 32'h1007 && stallLeft > 0) begin
                i_tx_ready = 1'b0;
                stallLeft--;
            end
            if (o_tx_valid) validCycles++;
            if (o_tx_valid && o_tx_data == 32'h1007) held7++;
            if (o_pipe_stall) stallCycles++;
            if (o_done) begin
                doneCount++;
                doneCycle = cyc;
            end
            if (o_tx_valid && i_tx_ready) begin
                expWord = (words == 0) ? 32'h0 : 32'h1000 + 32'(words);
                checkOutput($sformatf("word%0d", words), o_tx_data, expWord);
                words++;
            end
            if (!o_busy && cyc > 1) break;
            applyStimulus();
            cyc++;
        end
        i_dump_start = 1'b0;
        if (cyc >= 300) checkOutput("dump_timeout", 32'(cyc), 32'd0);
    endtask

    initial begin
        int words, validCycles, stallCycles, doneCount, doneCycle, held7;
        int guard;
        i_reset      = 1'b1;
        i_dump_start = 1'b0;
        i_halted     = 1'b0;
        i_pipe_rs    = 5'd5;
        i_pipe_rt    = 5'd9;
        i_tx_ready   = 1'b0;
        applyStimulus();
        applyStimulus();
        i_reset = 1'b0;
        #1;
        checkOutput("reset_addr1", 32'(o_rf_addr_1), 32'd5);
        checkOutput("reset_addr2", 32'(o_rf_addr_2), 32'd9);
        checkOutput("reset_valid", 32'(o_tx_valid), 32'd0);
        checkOutput("reset_busy", 32'(o_busy), 32'd0);
        checkOutput("reset_stall", 32'(o_pipe_stall), 32'd0);
        checkOutput("reset_done", 32'(o_done), 32'd0);
        checkOutput("reset_index", 32'(o_index), 32'd0);
        checkOutput("reset_data", o_tx_data, 32'd0);

        // Start while running is ignored
        i_dump_start = 1'b1;
        i_halted     = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("reject_busy", 32'(o_busy), 32'd0);
        checkOutput("reject_valid", 32'(o_tx_valid), 32'd0);
        i_dump_start = 1'b0;
        i_halted     = 1'b1;
        applyStimulus();
        checkOutput("reject_not_queued", 32'(o_busy), 32'd0);

        runDump(0, words, validCycles, stallCycles, doneCount, doneCycle, held7);
        checkOutput("full_words", 32'(words), 32'd32);
        checkOutput("full_valid_cycles", 32'(validCycles), 32'd32);
        checkOutput("full_stall_cycles", 32'(stallCycles), 32'd64);
        checkOutput("full_done_count", 32'(doneCount), 32'd1);
        checkOutput("full_done_cycle", 32'(doneCycle), 32'd65);
        checkOutput("full_idle_addr1", 32'(o_rf_addr_1), 32'd5);
        checkOutput("full_idle_index", 32'(o_index), 32'd0);
        checkOutput("full_idle_addr2", 32'(o_rf_addr_2), 32'd9);

        runDump(1, words, validCycles, stallCycles, doneCount, doneCycle, held7);
        checkOutput("bp_words", 32'(words), 32'd32);
        checkOutput("bp_held7", 32'(held7), 32'd4);
        checkOutput("bp_stall_cycles", 32'(stallCycles), 32'd67);
        checkOutput("bp_done_cycle", 32'(doneCycle), 32'd68);
        checkOutput("bp_done_count", 32'(doneCount), 32'd1);

        runDump(2, words, validCycles, stallCycles, doneCount, doneCycle, held7);
        checkOutput("busy_start_words", 32'(words), 32'd32);
        checkOutput("busy_start_done_count", 32'(doneCount), 32'd1);
        checkOutput("busy_start_done_cycle", 32'(doneCycle), 32'd65);

        // Reset while word 12 waits in SEND
        i_halted     = 1'b1;
        i_dump_start = 1'b1;
        i_tx_ready   = 1'b1;
        applyStimulus();
        i_dump_start = 1'b0;
        guard = 0;
        while (!(o_tx_valid && o_tx_data == 32'h100C) && guard < 100) begin
            applyStimulus();
            guard++;
        end
        checkOutput("reach_word12", 32'(o_tx_data), 32'h100C);
        i_tx_ready = 1'b0;
        i_reset    = 1'b1;
        applyStimulus();
        i_reset = 1'b0;
        checkOutput("abort_busy", 32'(o_busy), 32'd0);
        checkOutput("abort_valid", 32'(o_tx_valid), 32'd0);
        checkOutput("abort_index", 32'(o_index), 32'd0);
        checkOutput("abort_done", 32'(o_done), 32'd0);
        doneCount = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            if (o_done) doneCount++;
        end
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);

        runDump(0, words, validCycles, stallCycles, doneCount, doneCycle, held7);
        checkOutput("restart_words", 32'(words), 32'd32);
        checkOutput("restart_done_cycle", 32'(doneCycle), 32'd65);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
